// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared helpers for the single-clock FIFO family.
//   fifo_depth   - entry count for a given address width
//   ptr_empty    - empty decode from two (ASIZE+1)-bit binary pointers
//   ptr_full     - full decode from two (ASIZE+1)-bit binary pointers
//   params_legal - elaboration-time legality of ASIZE and thresholds
// Pointers are passed zero-extended to 32 bits together with ASIZE.
package sync_fifo_pkg;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  function automatic logic ptr_empty(input logic [31:0] wptr,
                                     input logic [31:0] rptr,
                                     input int          asize);
    logic [31:0] mask;
    mask = (32'd2 << asize) - 32'd1;
    return ((wptr ^ rptr) & mask) == 32'd0;
  endfunction

  // Full when only the wrap bit differs.
  function automatic logic ptr_full(input logic [31:0] wptr,
                                    input logic [31:0] rptr,
                                    input int          asize);
    logic [31:0] mask;
    mask = (32'd2 << asize) - 32'd1;
    return ((wptr ^ rptr) & mask) == (32'd1 << asize);
  endfunction

  function automatic bit params_legal(input int asize,
                                      input int afull_th,
                                      input int aempty_th);
    int depth;
    if (asize < 1 || asize > 30) return 1'b0;
    depth = fifo_depth(asize);
    return (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage, DSIZE x 2**ASIZE.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address (asynchronous read)
//   rdata - read data
// Contents are not reset.
module fifo_ram #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//   clk, rst       - clock, asynchronous active-high reset
//   wq, write_data - write request and data
//   rq, read_data  - read request (pop) and data
//   wfull, rempty, almost_full, almost_empty, count - occupancy status
//   overflow, underflow - sticky error flags, cleared by clr_err
// Build option: define SYNC_FIFO_FWFT_EN for first-word fall-through, where
// read_data shows the head entry whenever the FIFO is non-empty; otherwise
// read_data is a register loaded on each accepted read.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wq,
  input  logic [DSIZE-1:0] write_data,
  input  logic             rq,
  output logic [DSIZE-1:0] read_data,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  generate
    if (!params_legal(ASIZE, AFULL_TH, AEMPTY_TH)) begin : g_bad_params
      $error("sync_fifo_flags: illegal ASIZE/AFULL_TH/AEMPTY_TH combination");
    end
  endgenerate

  localparam logic [ASIZE:0] AFULL_C  = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY_C = AEMPTY_TH[ASIZE:0];

  logic [ASIZE:0]   wptr_p0;
  logic [ASIZE:0]   rptr_p0;
  logic             full_p0;
  logic             empty_p0;
  logic             wr_en;
  logic             rd_en;
  logic [DSIZE-1:0] ram_rdata;
  logic             ovf_p0;
  logic             unf_p0;

  // ---- stage p0: pointer state and flag decode ----
  assign full_p0  = ptr_full({{(31-ASIZE){1'b0}}, wptr_p0},
                             {{(31-ASIZE){1'b0}}, rptr_p0}, ASIZE);
  assign empty_p0 = ptr_empty({{(31-ASIZE){1'b0}}, wptr_p0},
                              {{(31-ASIZE){1'b0}}, rptr_p0}, ASIZE);

  assign wr_en = wq && !full_p0;
  assign rd_en = rq && !empty_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_p0 <= '0;
      rptr_p0 <= '0;
    end else begin
      if (wr_en) wptr_p0 <= wptr_p0 + 1'b1;
      if (rd_en) rptr_p0 <= rptr_p0 + 1'b1;
    end
  end

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_p0 <= 1'b0;
      unf_p0 <= 1'b0;
    end else begin
      if (wq && full_p0)   ovf_p0 <= 1'b1;
      else if (clr_err)    ovf_p0 <= 1'b0;
      if (rq && empty_p0)  unf_p0 <= 1'b1;
      else if (clr_err)    unf_p0 <= 1'b0;
    end
  end

  assign count        = wptr_p0 - rptr_p0;
  assign wfull        = full_p0;
  assign rempty       = empty_p0;
  assign almost_full  = count >= AFULL_C;
  assign almost_empty = count <= AEMPTY_C;
  assign overflow     = ovf_p0;
  assign underflow    = unf_p0;

  fifo_ram #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_p0[ASIZE-1:0]),
    .wdata (write_data),
    .raddr (rptr_p0[ASIZE-1:0]),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // ---- stage p0: head entry presented directly, forced to 0 when empty ----
  assign read_data = empty_p0 ? '0 : ram_rdata;
`else
  logic [DSIZE-1:0] rdata_p1;

  // ---- stage p1: registered read data ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata_p1 <= '0;
    else if (rd_en) rdata_p1 <= ram_rdata;
  end

  assign read_data = rdata_p1;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst;
  logic       wq;
  logic [7:0] write_data;
  logic       rq;
  logic [7:0] read_data;
  logic       wfull;
  logic       rempty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  sync_fifo_flags #(
    .DSIZE     (8),
    .ASIZE     (4),
    .AFULL_TH  (14),
    .AEMPTY_TH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wq           (wq),
    .write_data   (write_data),
    .rq           (rq),
    .read_data    (read_data),
    .wfull        (wfull),
    .rempty       (rempty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mq[$];     // model FIFO contents
  logic [7:0] exp_q[$];  // scoreboard of expected popped data
  int         mcount = 0;
  bit         mov = 0;
  bit         mun = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check($sformatf("%s.count", tag), 32'(count), 32'(mcount));
    check($sformatf("%s.rempty", tag), 32'(rempty), 32'(mcount == 0));
    check($sformatf("%s.wfull", tag), 32'(wfull), 32'(mcount == 16));
    check($sformatf("%s.almost_full", tag), 32'(almost_full), 32'(mcount >= 14));
    check($sformatf("%s.almost_empty", tag), 32'(almost_empty), 32'(mcount <= 2));
    check($sformatf("%s.overflow", tag), 32'(overflow), 32'(mov));
    check($sformatf("%s.underflow", tag), 32'(underflow), 32'(mun));
  endtask

  // Called at a negedge: drive one cycle of stimulus, update the model,
  // push expected read data, then check flags at the following negedge.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit c, input string tag);
    bit wacc;
    bit racc;
    wq = w; write_data = d; rq = r; clr_err = c;
    wacc = w && (mcount < 16);
    racc = r && (mcount > 0);
    if (racc) begin
      exp_q.push_back(mq.pop_front());
      mcount--;
    end
    if (wacc) begin
      mq.push_back(d);
      mcount++;
    end
    if (w && !wacc) mov = 1'b1;
    else if (c)     mov = 1'b0;
    if (r && !racc) mun = 1'b1;
    else if (c)     mun = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wq = 1'b0; rq = 1'b0; clr_err = 1'b0;
    check_flags(tag);
  endtask

  // Monitor: whenever a pop is accepted, compare the presented data with the
  // scoreboard head.
  bit         mon_fire;
  logic [7:0] mon_pre;
  always @(posedge clk) begin
    mon_pre  = read_data;
    mon_fire = rq && !rempty && !rst;
    #1;
    if (mon_fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_data: unexpected pop, got %0h, expected none", read_data);
      end else begin
`ifdef SYNC_FIFO_FWFT_EN
        check("read_data", 32'(mon_pre), 32'(exp_q.pop_front()));
`else
        check("read_data", 32'(read_data), 32'(exp_q.pop_front()));
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wq = 1'b0; rq = 1'b0; clr_err = 1'b0; write_data = 8'h00;
    repeat (2) @(negedge clk);
    check_flags("reset");
    check("reset.read_data", 32'(read_data), 32'h0);
    rst = 1'b0;

    // 1. Reset mid-stream with count=7 and non-zero read_data
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, "t1.wr");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "t1.rd");
    #2 rst = 1'b1;
    #1;
    mq.delete(); exp_q.delete(); mcount = 0; mov = 0; mun = 0;
    check("t1.async.count", 32'(count), 32'h0);
    check("t1.async.rempty", 32'(rempty), 32'h1);
    check("t1.async.read_data", 32'(read_data), 32'h0);
    wq = 1'b1; rq = 1'b1; write_data = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    check("t1.hold.count", 32'(count), 32'h0);
    check("t1.hold.rempty", 32'(rempty), 32'h1);
    wq = 1'b0; rq = 1'b0; rst = 1'b0;
    @(negedge clk);
    check_flags("t1.release");

    // 2. Fill, then overflow
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, "t2.fill");
    cycle(1'b1, 8'h21, 1'b0, 1'b0, "t2.ovf");

    // 3. Drain, then underflow
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "t3.drain");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "t3.unf");
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "t3.clr");

    // 4. Pointer wrap over three rounds
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'h30 + 8'(k * 10 + i), 1'b0, 1'b0, "t4.wr");
      for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "t4.rd");
    end

    // 5. Simultaneous write and read at mid, full and empty occupancy
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, "t5.pre");
    cycle(1'b1, 8'h60, 1'b1, 1'b0, "t5.mid");
    for (int i = 0; i < 11; i++) cycle(1'b1, 8'h61 + 8'(i), 1'b0, 1'b0, "t5.fill");
    cycle(1'b1, 8'h77, 1'b1, 1'b0, "t5.full");
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "t5.drain");
    cycle(1'b1, 8'h88, 1'b1, 1'b0, "t5.empty");

    // 6. Error clear alone, then clear coincident with a new underflow
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "t6.clr");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "t6.rd");
    cycle(1'b0, 8'h00, 1'b1, 1'b1, "t6.setwins");

`ifdef SYNC_FIFO_FWFT_EN
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, "t6.fwft");
    check("t6.fwft.read_data", 32'(read_data), 32'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "t6.fwft.pop");
`endif

    repeat (2) @(negedge clk);
    check("scoreboard.empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
